// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Decouples instruction fetch from decode with a ring of DEPTH slots.
//   Each slot holds the PC of an issued fetch request and, once the memory
//   answers, the 64-bit instruction pair. Three pointers walk the ring:
//   alloc (next slot to request), fill (next slot awaiting data) and
//   head (next slot to hand to decode). Pointers carry one extra wrap bit
//   so that full and empty can be told apart.
//
//   Optional feature: define FETCH_BUFFER_BYPASS_EN to let a response that
//   lands on an empty buffer go straight to decode in the same cycle.
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_pc                           current fetch PC from the program-state block
//   o_stall                        hold-PC indication back to the program-state block
//   i_flush                        discard all buffered and in-flight fetches
//   o_req_valid, o_req_addr        memory fetch request (address is i_pc)
//   i_req_ready                    memory accepts the request
//   i_resp_valid, i_resp_data      in-order fetch response (two instructions)
//   o_valid, o_pc, o_data          entry presented to decode
//   i_ready                        decode accepts the entry

`ifndef VADDR_WIDTH
`define VADDR_WIDTH 32
`endif

module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [`VADDR_WIDTH-1:0] i_pc,
  output logic                    o_stall,
  input  logic                    i_flush,
  output logic                    o_req_valid,
  output logic [`VADDR_WIDTH-1:0] o_req_addr,
  input  logic                    i_req_ready,
  input  logic                    i_resp_valid,
  input  logic [63:0]             i_resp_data,
  output logic                    o_valid,
  output logic [`VADDR_WIDTH-1:0] o_pc,
  output logic [63:0]             o_data,
  input  logic                    i_ready
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] DepthP = PW'(DEPTH);
  localparam logic [PW-1:0] One    = PW'(1);

  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q,  fill_d;
  logic [PW-1:0] head_q,  head_d;
  logic [PW-1:0] drop_q,  drop_d;

  logic [`VADDR_WIDTH-1:0] slotPc_q   [DEPTH];
  logic [63:0]             slotData_q [DEPTH];

  logic [PW-1:0] occupancy;
  logic [PW-1:0] outstanding;
  logic          reqFire;
  logic          respTake;
  logic          respDrop;
  logic          bypassHit;
  logic          deq;
  logic          slotWrite;

  // Request side: occupancy counts every allocated slot, filled or not,
  // so a request is only offered while a free slot exists.
  always_comb begin
    occupancy   = alloc_q - head_q;
    outstanding = alloc_q - fill_q;
    o_req_valid = ~i_flush & (occupancy < DepthP);
    o_stall     = ~(o_req_valid & i_req_ready);
    o_req_addr  = i_pc;
    reqFire     = o_req_valid & i_req_ready;
    // Responses belonging to flushed requests are swallowed until drop_q
    // reaches zero; only then do responses fill slots again.
    respTake    = i_resp_valid & (drop_q == '0);
    respDrop    = i_resp_valid & (drop_q != '0);
  end

  // Decode side: the head slot is presented whenever it has data. With the
  // bypass build an incoming response for the head slot is forwarded
  // directly; head == fill means the head slot is the one being filled.
  always_comb begin
`ifdef FETCH_BUFFER_BYPASS_EN
    bypassHit = (head_q == fill_q) & respTake;
`else
    bypassHit = 1'b0;
`endif
    o_valid   = (head_q != fill_q) | bypassHit;
    o_pc      = slotPc_q[head_q[IW-1:0]];
    o_data    = bypassHit ? i_resp_data : slotData_q[head_q[IW-1:0]];
    deq       = o_valid & i_ready & ~i_flush;
    // A forwarded-and-consumed response never needs to be stored.
    slotWrite = respTake & ~i_flush & ~(bypassHit & deq);
  end

  // Pointer and drop-counter next state. A flush rewinds the ring and
  // converts every request still waiting for data into a pending drop,
  // accounting for any response that arrives in the flush cycle itself.
  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    head_d  = head_q;
    drop_d  = drop_q;
    if (i_flush) begin
      alloc_d = '0;
      fill_d  = '0;
      head_d  = '0;
      drop_d  = outstanding - PW'(respTake) + drop_q - PW'(respDrop);
    end else begin
      if (reqFire) begin
        alloc_d = alloc_q + One;
      end
      if (respTake) begin
        fill_d = fill_q + One;
      end
      if (respDrop) begin
        drop_d = drop_q - One;
      end
      if (deq) begin
        head_d = head_q + One;
      end
    end
  end

  // Pointer state clears immediately on reset; outstanding memory traffic
  // is abandoned because the memory side is reset alongside this block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      drop_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
      drop_q  <= drop_d;
    end
  end

  // Slot storage has no reset; a slot is only read after it is written.
  always_ff @(posedge i_clk) begin
    if (reqFire) begin
      slotPc_q[alloc_q[IW-1:0]] <= i_pc;
    end
    if (slotWrite) begin
      slotData_q[fill_q[IW-1:0]] <= i_resp_data;
    end
  end

endmodule
